// File: rtl/pe_cfg_seq.sv
// Configuration and frame sequencer for a daisy-chained PE array.
// Streams weights and control words into PE0, then gates one frame of pixel enables.
module pe_cfg_seq #(
  parameter int N_PE  = 4,
  parameter int M     = 4,
  parameter int CL_IN = 4,
  parameter int CL1   = 2,
  parameter int LINES = 16,
  parameter int DRAIN = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      reload_i,
  input  logic                      abort_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [M-1:0]              w_data_i,
  input  logic                      c_valid_i,
  output logic                      c_ready_o,
  input  logic [2*CL_IN+CL1-1:0]    c_data_i,
  input  logic                      pix_valid_i,
  output logic                      w_conf_o,
  output logic [M-1:0]              w_out_o,
  output logic                      cntl_conf_o,
  output logic [CL_IN-1:0]          d_ch_out_o,
  output logic [CL_IN-1:0]          bp_ch_out_o,
  output logic [CL1-1:0]            bp_src_out_o,
  output logic                      pe_en_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      cfg_ok_o
);

  localparam int W_TC = 9*N_PE - 1;
  localparam int C_TC = N_PE - 1;
  localparam int P_TC = LINES*LINES - 1;
  localparam int D_TC = DRAIN;
  localparam int WCW  = $clog2(W_TC) + 1;
  localparam int CCW  = $clog2(C_TC) + 1;
  localparam int PCW  = $clog2(P_TC) + 1;
  localparam int DCW  = $clog2(D_TC) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_C, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   w_cnt_q, w_cnt_d;
  logic [CCW-1:0]   c_cnt_q, c_cnt_d;
  logic [PCW-1:0]   p_cnt_q, p_cnt_d;
  logic [DCW-1:0]   d_cnt_q, d_cnt_d;
  logic             cfg_ok_q, cfg_ok_d;
  logic             w_conf_q, cntl_conf_q, pe_en_q, frame_done_q;
  logic [M-1:0]     w_out_q;
  logic [2*CL_IN+CL1-1:0] c_word_q;
  logic             w_acc, c_acc, p_acc;

  assign w_acc = (state_q == S_LOAD_W) && w_valid_i;
  assign c_acc = (state_q == S_LOAD_C) && c_valid_i;
  assign p_acc = (state_q == S_RUN) && pix_valid_i;

  always_comb begin
    state_d  = state_q;
    w_cnt_d  = w_cnt_q;
    c_cnt_d  = c_cnt_q;
    p_cnt_d  = p_cnt_q;
    d_cnt_d  = d_cnt_q;
    cfg_ok_d = cfg_ok_q;
    if (abort_i) begin
      state_d = S_IDLE;
      w_cnt_d = '0;
      c_cnt_d = '0;
      p_cnt_d = '0;
      d_cnt_d = '0;
      if (state_q == S_LOAD_W || state_q == S_LOAD_C) cfg_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          if (reload_i || !cfg_ok_q) begin
            state_d  = S_LOAD_W;
            cfg_ok_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
        S_LOAD_W: if (w_acc) begin
          if (w_cnt_q == WCW'(W_TC)) begin
            w_cnt_d = '0;
            state_d = S_LOAD_C;
          end else begin
            w_cnt_d = w_cnt_q + WCW'(1);
          end
        end
        S_LOAD_C: if (c_acc) begin
          if (c_cnt_q == CCW'(C_TC)) begin
            c_cnt_d  = '0;
            state_d  = S_RUN;
            cfg_ok_d = 1'b1;
          end else begin
            c_cnt_d = c_cnt_q + CCW'(1);
          end
        end
        S_RUN: if (p_acc) begin
          if (p_cnt_q == PCW'(P_TC)) begin
            p_cnt_d = '0;
            state_d = S_DRAIN;
          end else begin
            p_cnt_d = p_cnt_q + PCW'(1);
          end
        end
        // First DRAIN cycle carries the last pe_en; DRAIN more follow it.
        S_DRAIN: begin
          if (d_cnt_q == DCW'(D_TC)) begin
            d_cnt_d = '0;
            state_d = S_DONE;
          end else begin
            d_cnt_d = d_cnt_q + DCW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      w_cnt_q      <= '0;
      c_cnt_q      <= '0;
      p_cnt_q      <= '0;
      d_cnt_q      <= '0;
      cfg_ok_q     <= 1'b0;
      w_conf_q     <= 1'b0;
      cntl_conf_q  <= 1'b0;
      pe_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      w_out_q      <= '0;
      c_word_q     <= '0;
    end else begin
      state_q      <= state_d;
      w_cnt_q      <= w_cnt_d;
      c_cnt_q      <= c_cnt_d;
      p_cnt_q      <= p_cnt_d;
      d_cnt_q      <= d_cnt_d;
      cfg_ok_q     <= cfg_ok_d;
      w_conf_q     <= w_acc && !abort_i;
      cntl_conf_q  <= c_acc && !abort_i;
      pe_en_q      <= p_acc && !abort_i;
      frame_done_q <= (state_d == S_DONE);
      if (w_acc && !abort_i) w_out_q  <= w_data_i;
      if (c_acc && !abort_i) c_word_q <= c_data_i;
    end
  end

  assign w_ready_o    = (state_q == S_LOAD_W);
  assign c_ready_o    = (state_q == S_LOAD_C);
  assign busy_o       = (state_q != S_IDLE);
  assign cfg_ok_o     = cfg_ok_q;
  assign w_conf_o     = w_conf_q;
  assign w_out_o      = w_out_q;
  assign cntl_conf_o  = cntl_conf_q;
  assign d_ch_out_o   = c_word_q[CL_IN-1:0];
  assign bp_ch_out_o  = c_word_q[2*CL_IN-1:CL_IN];
  assign bp_src_out_o = c_word_q[2*CL_IN+CL1-1:2*CL_IN];
  assign pe_en_o      = pe_en_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_pe_cfg_seq.sv
// Scoreboard bench for pe_cfg_seq: weight/control words queued on drive and
// popped when the chain strobes appear; frame timing checked against the last strobe.
module tb_pe_cfg_seq;

  localparam int N_PE = 2, M = 8, CL_IN = 4, CL1 = 2, LINES = 4, DRAIN = 3;
  localparam int CW = 2*CL_IN + CL1;
  localparam int NW = 9*N_PE;
  localparam int NPIX = LINES*LINES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, reload = 1'b0, abort = 1'b0;
  logic w_valid = 1'b0, c_valid = 1'b0, pix_valid = 1'b0;
  logic [M-1:0]  w_data = '0;
  logic [CW-1:0] c_data = '0;
  logic w_ready, c_ready, w_conf, cntl_conf, pe_en, busy, frame_done, cfg_ok;
  logic [M-1:0] w_out;
  logic [CL_IN-1:0] d_ch, bp_ch;
  logic [CL1-1:0] bp_src;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int w_pulses, c_pulses, pe_cnt, fd_cnt, fd_cyc, w_run, w_max, last_pix;
  logic [M-1:0]  wq[$];
  logic [CW-1:0] cq[$];

  pe_cfg_seq #(.N_PE(N_PE), .M(M), .CL_IN(CL_IN), .CL1(CL1), .LINES(LINES), .DRAIN(DRAIN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .reload_i(reload), .abort_i(abort),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_data_i(c_data),
    .pix_valid_i(pix_valid), .w_conf_o(w_conf), .w_out_o(w_out),
    .cntl_conf_o(cntl_conf), .d_ch_out_o(d_ch), .bp_ch_out_o(bp_ch), .bp_src_out_o(bp_src),
    .pe_en_o(pe_en), .busy_o(busy), .frame_done_o(frame_done), .cfg_ok_o(cfg_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (w_conf) begin
        w_pulses++;
        w_run++;
        if (w_run > w_max) w_max = w_run;
        if (wq.size() == 0) chk("w_conf_unexpected", 1, 0);
        else chk("w_out", 32'(w_out), 32'(wq.pop_front()));
      end else begin
        w_run = 0;
      end
      if (cntl_conf) begin
        c_pulses++;
        if (cq.size() == 0) chk("cntl_conf_unexpected", 1, 0);
        else chk("ctrl_word", 32'({bp_src, bp_ch, d_ch}), 32'(cq.pop_front()));
      end
      if (pe_en) pe_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    w_pulses = 0; c_pulses = 0; pe_cnt = 0; fd_cnt = 0; fd_cyc = 0;
    w_run = 0; w_max = 0; last_pix = 0;
  endtask

  task automatic start_job(input logic rl);
    start = 1'b1; reload = rl;
    tick();
    start = 1'b0; reload = 1'b0;
  endtask

  task automatic load_weights(input bit stall);
    for (int i = 1; i <= NW; i++) begin
      if (stall && i > 1) begin
        w_valid = 1'b0;
        tick();
      end
      w_valid = 1'b1;
      w_data  = M'(i);
      wq.push_back(M'(i));
      tick();
      if (i == NW-1) chk("w_ready_before_last", 32'(w_ready), 1);
    end
    w_valid = 1'b0;
    chk("w_ready_after_last", 32'(w_ready), 0);
    chk("c_ready_in_load_c", 32'(c_ready), 1);
  endtask

  task automatic load_ctrl();
    c_valid = 1'b1;
    c_data = 10'h0F1; cq.push_back(10'h0F1);
    tick();
    chk("cfg_ok_mid_ctrl", 32'(cfg_ok), 0);
    c_data = 10'h0F2; cq.push_back(10'h0F2);
    tick();
    c_valid = 1'b0;
    chk("cfg_ok_after_ctrl", 32'(cfg_ok), 1);
    chk("c_ready_in_run", 32'(c_ready), 0);
  endtask

  task automatic send_pix(input int n);
    for (int p = 0; p < n; p++) begin
      pix_valid = 1'b1;
      last_pix = cyc;
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30 && fd_cnt == 0; k++) tick();
    tick(); tick();
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_latency", fd_cyc - last_pix, DRAIN + 2);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    clr_stats();
    // reset with start held
    start = 1'b1; reload = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ok", 32'(cfg_ok), 0);
    chk("rst_flags", 32'({w_conf, cntl_conf, pe_en, frame_done, w_ready, c_ready}), 0);
    chk("rst_data", 32'({w_out, d_ch, bp_ch, bp_src}), 0);
    start = 1'b0; reload = 1'b0;
    rst = 1'b1;
    tick();

    // full load and run
    clr_stats();
    start_job(1'b1);
    chk("load_busy", 32'(busy), 1);
    chk("load_w_ready", 32'(w_ready), 1);
    load_weights(1'b0);
    load_ctrl();
    send_pix(NPIX);
    wait_done();
    chk("full_w_pulses", w_pulses, NW);
    chk("full_w_consecutive", w_max, NW);
    chk("full_c_pulses", c_pulses, N_PE);
    chk("full_pe_en", pe_cnt, NPIX);
    chk("full_cfg_ok", 32'(cfg_ok), 1);

    // reuse without reload; a stray strobe in IDLE must be ignored
    clr_stats();
    pix_valid = 1'b1; tick(); pix_valid = 1'b0;
    start_job(1'b0);
    chk("reuse_busy", 32'(busy), 1);
    chk("reuse_no_w_ready", 32'(w_ready), 0);
    send_pix(NPIX);
    wait_done();
    chk("reuse_w_pulses", w_pulses, 0);
    chk("reuse_c_pulses", c_pulses, 0);
    chk("reuse_pe_en", pe_cnt, NPIX);

    // stalled weight stream
    clr_stats();
    start_job(1'b1);
    chk("stall_cfg_cleared", 32'(cfg_ok), 0);
    load_weights(1'b1);
    load_ctrl();
    send_pix(NPIX);
    wait_done();
    chk("stall_w_pulses", w_pulses, NW);
    chk("stall_w_toggle", w_max, 1);
    chk("stall_pe_en", pe_cnt, NPIX);

    // abort mid-load at weight 7
    clr_stats();
    start_job(1'b1);
    for (int i = 1; i <= 6; i++) begin
      w_valid = 1'b1; w_data = M'(i); wq.push_back(M'(i));
      tick();
    end
    w_valid = 1'b1; w_data = 8'd7; abort = 1'b1;
    tick();
    w_valid = 1'b0; abort = 1'b0;
    chk("abort_load_busy", 32'(busy), 0);
    chk("abort_load_cfg_ok", 32'(cfg_ok), 0);
    tick(); tick();
    chk("abort_load_w_pulses", w_pulses, 6);
    start_job(1'b0);
    chk("abort_restart_load_w", 32'(w_ready), 1);
    clr_stats();
    load_weights(1'b0);
    load_ctrl();
    send_pix(NPIX);
    wait_done();
    chk("abort_restart_w_pulses", w_pulses, NW);

    // abort in RUN at pixel 10
    clr_stats();
    start_job(1'b0);
    send_pix(10);
    pix_valid = 1'b1; abort = 1'b1;
    tick();
    pix_valid = 1'b0; abort = 1'b0;
    chk("abort_run_busy", 32'(busy), 0);
    repeat (12) tick();
    chk("abort_run_pe_en", pe_cnt, 10);
    chk("abort_run_no_done", fd_cnt, 0);
    chk("abort_run_cfg_ok", 32'(cfg_ok), 1);
    chk("sb_w_empty", wq.size(), 0);
    chk("sb_c_empty", cq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
